// File: rtl/first_zero_alloc_if.sv
// Allocator bus: alloc request handshake, registered grant response,
// slot release and occupancy status.
//   master: requester side (drives alloc_valid, rsp_ready, free_valid, free_idx)
//   slave : allocator side (drives alloc_ready, rsp_*, free_err, free_cnt, full)
interface first_zero_alloc_if #(
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             alloc_valid;
  logic             alloc_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_ok;
  logic [IDX_W-1:0] rsp_idx;
  logic [WIDTH-1:0] rsp_mask;
  logic             free_valid;
  logic [IDX_W-1:0] free_idx;
  logic             free_err;
  logic [IDX_W:0]   free_cnt;
  logic             full;

  modport master (
    output alloc_valid, rsp_ready, free_valid, free_idx,
    input  alloc_ready, rsp_valid, rsp_ok, rsp_idx, rsp_mask,
           free_err, free_cnt, full
  );

  modport slave (
    input  alloc_valid, rsp_ready, free_valid, free_idx,
    output alloc_ready, rsp_valid, rsp_ok, rsp_idx, rsp_mask,
           free_err, free_cnt, full
  );
endinterface

// File: rtl/first_zero_alloc.sv
// first_zero_alloc: free-slot allocator over a WIDTH-bit occupancy bitmap
// (1 = used). An accepted alloc request grants the first free slot
// (lowest index, or highest when MSB_FIRST=1) one cycle later through a
// 1-deep response register; free requests release slots.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (frees all slots, drops response)
//   bus    first_zero_alloc_if.slave: alloc_valid/alloc_ready,
//          rsp_valid/rsp_ready/rsp_ok/rsp_idx/rsp_mask,
//          free_valid/free_idx/free_err, free_cnt, full
module first_zero_alloc #(
  parameter int unsigned WIDTH     = 64,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  first_zero_alloc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] bitmap_q,   bitmap_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_ok_q,   rsp_ok_d;
  logic [IDX_W-1:0] rsp_idx_q,  rsp_idx_d;
  logic [WIDTH-1:0] rsp_mask_q, rsp_mask_d;
  logic             free_err_q, free_err_d;
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;

  logic             alloc_ready;
  logic             accept;
  logic             found;
  logic             grant;
  logic             free_hit;
  logic [WIDTH-1:0] scan;
  logic [WIDTH-1:0] scan_onehot;
  logic [WIDTH-1:0] first_onehot;
  logic [IDX_W-1:0] first_idx;

  // First-zero search on the registered bitmap. MSB-first reuses the
  // LSB-first isolate trick on the bit-reversed bitmap and reverses back.
  always_comb begin
    scan         = '0;
    first_onehot = '0;
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        scan[i] = bitmap_q[WIDTH-1-i];
      end
    end else begin
      scan = bitmap_q;
    end

    scan_onehot = ~scan & (scan + WIDTH'(1));

    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        first_onehot[i] = scan_onehot[WIDTH-1-i];
      end
    end else begin
      first_onehot = scan_onehot;
    end

    first_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (first_onehot[i]) begin
        first_idx = first_idx | IDX_W'(i);
      end
    end
    found = |first_onehot;
  end

  assign alloc_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept      = bus.alloc_valid && alloc_ready;
  assign grant       = accept && found;
  assign free_hit    = bus.free_valid && bitmap_q[bus.free_idx];

  // A successful free targets a set bit while a grant targets a clear bit,
  // so both bitmap updates can be applied in the same edge without conflict.
  always_comb begin
    bitmap_d    = bitmap_q;
    free_cnt_d  = free_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_mask_d  = rsp_mask_q;
    free_err_d  = bus.free_valid && !bitmap_q[bus.free_idx];

    if (grant) begin
      bitmap_d = bitmap_d | first_onehot;
    end
    if (free_hit) begin
      bitmap_d[bus.free_idx] = 1'b0;
    end
    free_cnt_d = free_cnt_q - CNT_W'(grant) + CNT_W'(free_hit);

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_ok_d    = found;
      rsp_idx_d   = first_idx;
      rsp_mask_d  = first_onehot;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitmap_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_mask_q  <= '0;
      free_err_q  <= 1'b0;
      free_cnt_q  <= CNT_W'(WIDTH);
    end else begin
      bitmap_q    <= bitmap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_mask_q  <= rsp_mask_d;
      free_err_q  <= free_err_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_ok      = rsp_ok_q;
  assign bus.rsp_idx     = rsp_idx_q;
  assign bus.rsp_mask    = rsp_mask_q;
  assign bus.free_err    = free_err_q;
  assign bus.free_cnt    = free_cnt_q;
  assign bus.full        = (free_cnt_q == '0);
endmodule

// File: tb/tb_first_zero_alloc.sv
module tb_first_zero_alloc;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  first_zero_alloc_if #(.WIDTH(8)) bus0 ();
  first_zero_alloc_if #(.WIDTH(8)) bus1 ();

  first_zero_alloc #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0), .bus(bus0)
  );
  first_zero_alloc #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1), .bus(bus1)
  );

  typedef struct {
    logic       ok;
    logic [2:0] idx;
    logic [7:0] mask;
  } rsp_t;

  rsp_t       sbq[$];
  logic [7:0] mbm;
  int         mcnt;
  bit         mrv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset0();
    rst0 = 1'b0;
    bus0.alloc_valid = 1'b0;
    bus0.rsp_ready   = 1'b0;
    bus0.free_valid  = 1'b0;
    bus0.free_idx    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 0);
    chk("rst_rsp_ok",    32'(bus0.rsp_ok), 0);
    chk("rst_rsp_idx",   32'(bus0.rsp_idx), 0);
    chk("rst_rsp_mask",  32'(bus0.rsp_mask), 0);
    chk("rst_free_err",  32'(bus0.free_err), 0);
    chk("rst_free_cnt",  32'(bus0.free_cnt), 8);
    chk("rst_full",      32'(bus0.full), 0);
    rst0 = 1'b1;
    mbm  = '0;
    mcnt = 8;
    mrv  = 1'b0;
    sbq.delete();
  endtask

  // One clock of DUT0 with inputs already driven: compare against the
  // model, update the model/scoreboard, advance one edge, compare status.
  task automatic cyc();
    logic [7:0] pre;
    bit         acc;
    bit         cons;
    bit         ferr;
    rsp_t       e;
    int         g;
    #1;
    pre = mbm;
    chk("alloc_ready", 32'(bus0.alloc_ready), 32'(!mrv || bus0.rsp_ready));
    cons = mrv && bus0.rsp_ready;
    if (mrv && sbq.size() > 0) begin
      chk("rsp_ok",   32'(bus0.rsp_ok),   32'(sbq[0].ok));
      chk("rsp_idx",  32'(bus0.rsp_idx),  32'(sbq[0].idx));
      chk("rsp_mask", 32'(bus0.rsp_mask), 32'(sbq[0].mask));
      if (cons) void'(sbq.pop_front());
    end
    acc = bus0.alloc_valid && (!mrv || bus0.rsp_ready);
    if (acc) begin
      g = -1;
      for (int i = 0; i < 8; i++) begin
        if (g < 0 && !pre[i]) g = i;
      end
      if (g >= 0) begin
        e.ok   = 1'b1;
        e.idx  = 3'(g);
        e.mask = 8'(1 << g);
        mbm[g] = 1'b1;
        mcnt--;
      end else begin
        e.ok   = 1'b0;
        e.idx  = '0;
        e.mask = '0;
      end
      sbq.push_back(e);
    end
    ferr = bus0.free_valid && !pre[bus0.free_idx];
    if (bus0.free_valid && pre[bus0.free_idx]) begin
      mbm[bus0.free_idx] = 1'b0;
      mcnt++;
    end
    mrv = acc ? 1'b1 : (cons ? 1'b0 : mrv);
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(bus0.rsp_valid), 32'(mrv));
    chk("free_cnt",  32'(bus0.free_cnt), 32'(mcnt));
    chk("full",      32'(bus0.full), 32'(mcnt == 0));
    chk("free_err",  32'(bus0.free_err), 32'(ferr));
    #(-2 + 2); // keep task ending at posedge+1; next cyc adds its own settle delay
  endtask

  initial begin
    bus1.alloc_valid = 1'b0;
    bus1.rsp_ready   = 1'b0;
    bus1.free_valid  = 1'b0;
    bus1.free_idx    = '0;

    // 1: eight back-to-back grants 0..7, then full
    reset0();
    bus0.alloc_valid = 1'b1;
    bus0.rsp_ready   = 1'b1;
    repeat (8) cyc();
    bus0.alloc_valid = 1'b0;
    cyc();
    chk("t1_full", 32'(bus0.full), 1);
    chk("t1_free_cnt", 32'(bus0.free_cnt), 0);

    // 2: alloc while full
    bus0.alloc_valid = 1'b1;
    cyc();
    chk("t2_rsp_ok", 32'(bus0.rsp_ok), 0);
    chk("t2_rsp_mask", 32'(bus0.rsp_mask), 0);
    bus0.alloc_valid = 1'b0;
    cyc();

    // 3: free 3 together with alloc while full, then alloc gets 3
    bus0.alloc_valid = 1'b1;
    bus0.free_valid  = 1'b1;
    bus0.free_idx    = 3'd3;
    cyc();
    chk("t3_fail_ok", 32'(bus0.rsp_ok), 0);
    chk("t3_free_cnt", 32'(bus0.free_cnt), 1);
    bus0.alloc_valid = 1'b0;
    bus0.free_valid  = 1'b0;
    cyc();
    bus0.alloc_valid = 1'b1;
    cyc();
    chk("t3_idx", 32'(bus0.rsp_idx), 3);
    chk("t3_mask", 32'(bus0.rsp_mask), 32'h08);
    bus0.alloc_valid = 1'b0;
    cyc();

    // 4: bitmap 0x0F, backpressure holds grant 4, then grant 5
    reset0();
    bus0.alloc_valid = 1'b1;
    bus0.rsp_ready   = 1'b1;
    repeat (4) cyc();
    bus0.alloc_valid = 1'b0;
    cyc();
    bus0.alloc_valid = 1'b1;
    bus0.rsp_ready   = 1'b0;
    repeat (3) begin
      cyc();
      chk("t4_hold_idx", 32'(bus0.rsp_idx), 4);
      chk("t4_alloc_ready", 32'(bus0.alloc_ready), 0);
    end
    bus0.rsp_ready = 1'b1;
    cyc();
    chk("t4_next_idx", 32'(bus0.rsp_idx), 5);
    bus0.alloc_valid = 1'b0;
    cyc();

    // 5: free of a clear bit, then a normal free
    bus0.free_valid = 1'b1;
    bus0.free_idx   = 3'd6;
    cyc();
    chk("t5_free_err", 32'(bus0.free_err), 1);
    chk("t5_free_cnt", 32'(bus0.free_cnt), 2);
    bus0.free_idx = 3'd0;
    cyc();
    bus0.free_valid = 1'b0;
    cyc();

    // 6: MSB-first instance, bitmap 0x81 grants 6; reset drops response
    @(posedge clk);
    rst1 = 1'b1;
    bus1.alloc_valid = 1'b1;
    bus1.rsp_ready   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("m_seq_idx", 32'(bus1.rsp_idx), 32'(7 - k));
    end
    bus1.alloc_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("m_full", 32'(bus1.full), 1);
    for (int k = 6; k >= 1; k--) begin
      bus1.free_valid = 1'b1;
      bus1.free_idx   = 3'(k);
      @(posedge clk);
      #1;
    end
    bus1.free_valid = 1'b0;
    chk("m_free_cnt", 32'(bus1.free_cnt), 6);
    bus1.alloc_valid = 1'b1;
    bus1.rsp_ready   = 1'b0;
    @(posedge clk);
    #1;
    bus1.alloc_valid = 1'b0;
    chk("m_ok", 32'(bus1.rsp_ok), 1);
    chk("m_idx", 32'(bus1.rsp_idx), 6);
    chk("m_mask", 32'(bus1.rsp_mask), 32'h40);
    chk("m_rsp_valid", 32'(bus1.rsp_valid), 1);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    chk("m_rst_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("m_rst_free_cnt", 32'(bus1.free_cnt), 8);
    chk("m_rst_full", 32'(bus1.full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
